sregs_irq_nest: RTL and testbench
=================================

Name: sregs_irq_nest

Overview:
- Next-generation special-register file for the pcpu core.
- Holds mode, boot, flag, exception-PC and interrupt-control registers.
- Adds IRQ_N edge-latched interrupt lines with mask, pending and cause registers, and priority selection.
- Adds a NEST_DEPTH-deep save stack of {pc, flags, mode}, so interrupts can nest and be returned from.
- Sits beside the decoder/PC unit: PC unit consumes irq_take/irq_vec and ret_valid/ret_pc.

Parameters:
- DW, 16, data/address width of registers and PC.
- IRQ_N, 4, number of interrupt lines (1..16).
- NEST_DEPTH, 2, save-stack entries (1..8).
- FW, 5, ALU flag width.
- VEC_BASE, 16'h0010, vector base; irq_vec = VEC_BASE + 4*cause.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sr_we  in  1  special-register write strobe
- sr_sel  in  DW  register select
- sr_in  in  DW  write data
- sr_out  out  DW  combinational read data for sr_sel
- boot_commit  in  1  copy boot buffer into boot_mode (decoder pulse)
- boot_mode  out  1  boot-ROM mapping active
- instr_mem_over  out  1  MODE.INA
- supervisor  out  1  MODE.SUP
- irq_en  out  1  MODE.IE
- irq_lines  in  IRQ_N  raw interrupt requests
- instr_boundary  in  1  core may be interrupted this cycle
- pc_next  in  DW  address of next instruction to execute
- irq_take  out  1  one-cycle pulse: jump to irq_vec
- irq_vec  out  DW  vector address, valid with irq_take
- iret  in  1  return-from-interrupt pulse
- ret_valid  out  1  one-cycle pulse: jump to ret_pc
- ret_pc  out  DW  popped PC
- alu_flags_in  in  FW  flags from ALU
- alu_flags_ie  in  1  flag update strobe
- alu_flags  out  FW  current flags

Behaviour:
- Reset values: MODE={IE=0,INA=0,SUP=1}, boot buffer=1, boot_mode=1, FLAGS=0, IMASK=0, IPEND=0, ICAUSE=0, depth=0, ERR=0. All pulse outputs are 0; ret_pc and irq_vec are 0.
- Register map (sr_sel):
  - 1 MODE[2:0] {IE,INA,SUP}: writes ignored unless SUP=1.
  - 2 BOOT buffer, bit0.
  - 3 EPC: top-of-stack PC, read/write; reads 0 when depth=0.
  - 4 FLAGS.
  - 5 IMASK.
  - 6 IPEND: write-1-to-clear.
  - 7 ICAUSE, read-only: [3:0] cause, [11:8] depth, [15] ERR; a write of any value clears ERR.
  - Other selects read 0 and ignore writes.
- Edge detect: irq_lines are registered once; a 0->1 transition sets IPEND[i] the following cycle. An IPEND set and a W1C clear of the same bit in one cycle: set wins.
- Eligible = IPEND & IMASK, gated by IE=1, instr_boundary=1, depth<NEST_DEPTH and iret=0.
- Winner: lowest index among eligible bits (see optional feature).
- Take cycle, all registered on the same edge:
  - push {pc_next, FLAGS, MODE} and increment depth;
  - clear IPEND[winner]; set ICAUSE=winner;
  - MODE.SUP=1, MODE.IE=0.
  - irq_take=1 and irq_vec valid in the cycle after the take decision; latency from line edge to irq_take is 3 cycles minimum.
- iret with depth>0:
  - pop, restore FLAGS and MODE from the entry, decrement depth;
  - ret_valid=1 next cycle with ret_pc = popped PC.
- iret with depth=0: no pop, ret_valid stays 0, ERR=1.
- Priority of simultaneous events:
  - iret beats take; take is retried next eligible cycle.
  - Take/pop beat an sr_we to MODE or FLAGS in the same cycle.
  - alu_flags_ie beats an sr_we to FLAGS; take/pop beat alu_flags_ie.
- EPC write modifies the top entry only; ignored when depth=0.
- boot_commit: boot_mode <= boot buffer.
- rst asserted mid-handler: stack and depth clear immediately; pulse outputs drop.

Optional Feature:
- Macro: SREGS_IRQ_PRIO_EN.
- Defined: sr_sel 8 is the IPRIO register (IRQ_N bits, reset 0). Eligible lines with IPRIO=1 win over IPRIO=0, lowest index within a group. A higher-priority line may pre-empt a running handler only if software re-sets IE.
- Undefined: fixed lowest-index priority; sel 8 reads 0 and ignores writes.

Decomposition:
- Shared package sregs_pkg:
  - select constants SR_MODE..SR_IPRIO;
  - MODE bit indices;
  - stack-entry struct {pc, flags, mode}.
- One sub-module, irq_prio_enc: parametrised priority encoder returning valid and index.

Test Plan:
- Reset, read sel 1/4/7 -> 16'h0001, 0, 0; boot_mode=1; write MODE=0 then MODE=7 -> reads 0 (second write blocked once SUP=0).
- IMASK=4'b0110, IE=1, pulse lines 1 and 2 together, boundary=1, pc_next=16'h0123 -> irq_take with irq_vec=16'h0014; ICAUSE=1; EPC=16'h0123; IPEND=4'b0100.
- Handler sets IE=1, line 2 pending -> nested take, depth=2; line 3 edge with IMASK[3]=1 -> no take (stack full); two irets -> ret_pc sequence matches the two pushed PCs; MODE/FLAGS restored.
- iret at depth=0 -> no ret_valid, ICAUSE[15]=1; write sel 7 -> ERR=0.
- iret and eligible IRQ in the same cycle -> pop first; take occurs next cycle.
- With SREGS_IRQ_PRIO_EN, IPRIO=4'b1000, lines 0 and 3 pending -> cause=3; without the macro -> cause=0.

Source files
------------

// File: rtl/sregs_pkg.sv
// Shared definitions for the pcpu special-register file.
//   - SR_* : sr_sel encodings of the architected special registers
//   - MODE_* : bit positions inside the MODE register {IE, INA, SUP}
//   - sr_stack_t : one interrupt save-stack entry {pc, flags, mode}
// The stack entry is sized by SR_DW/SR_FW; the register file's DW/FW
// parameters default to these values and must stay equal to them.
package sregs_pkg;

  localparam int SR_DW = 16;
  localparam int SR_FW = 5;

  localparam int SR_MODE   = 1;
  localparam int SR_BOOT   = 2;
  localparam int SR_EPC    = 3;
  localparam int SR_FLAGS  = 4;
  localparam int SR_IMASK  = 5;
  localparam int SR_IPEND  = 6;
  localparam int SR_ICAUSE = 7;
  localparam int SR_IPRIO  = 8;

  localparam int MODE_W   = 3;
  localparam int MODE_SUP = 0;
  localparam int MODE_INA = 1;
  localparam int MODE_IE  = 2;

  // Depth counter wide enough for up to 8 nested entries.
  localparam int DEPTH_W = 4;
  localparam int CAUSE_W = 4;

  typedef struct packed {
    logic [SR_DW-1:0]  pc;
    logic [SR_FW-1:0]  flags;
    logic [MODE_W-1:0] mode;
  } sr_stack_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req wins.
//   req   in  N   request vector
//   valid out 1   any request set
//   idx   out IW  index of the winning request (0 when none)
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/sregs_irq_nest.sv
// Special-register file for the pcpu core with nested interrupts.
// Holds MODE/BOOT/FLAGS plus interrupt mask, pending, cause and a save stack
// of {pc, flags, mode} so handlers can nest and return.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   sr_we/sr_sel/sr_in  special-register write port
//   sr_out              combinational read data for sr_sel
//   boot_commit         copies the boot buffer into boot_mode
//   boot_mode, instr_mem_over, supervisor, irq_en   mode status outputs
//   irq_lines           raw interrupt requests (edge detected)
//   instr_boundary      core may be interrupted this cycle
//   pc_next             PC saved on an interrupt take
//   irq_take/irq_vec    registered pulse + vector to the PC unit
//   iret                return-from-interrupt request
//   ret_valid/ret_pc    registered pulse + popped PC to the PC unit
//   alu_flags_in/alu_flags_ie/alu_flags   ALU flag update and current flags
//
// Build option: define SREGS_IRQ_PRIO_EN to add the IPRIO register at
// sr_sel 8; lines with IPRIO=1 then win over lines with IPRIO=0.
module sregs_irq_nest
  import sregs_pkg::*;
#(
  parameter int              DW         = SR_DW,
  parameter int              IRQ_N      = 4,
  parameter int              NEST_DEPTH = 2,
  parameter int              FW         = SR_FW,
  parameter logic [DW-1:0]   VEC_BASE   = 16'h0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sr_we,
  input  logic [DW-1:0]    sr_sel,
  input  logic [DW-1:0]    sr_in,
  output logic [DW-1:0]    sr_out,
  input  logic             boot_commit,
  output logic             boot_mode,
  output logic             instr_mem_over,
  output logic             supervisor,
  output logic             irq_en,
  input  logic [IRQ_N-1:0] irq_lines,
  input  logic             instr_boundary,
  input  logic [DW-1:0]    pc_next,
  output logic             irq_take,
  output logic [DW-1:0]    irq_vec,
  input  logic             iret,
  output logic             ret_valid,
  output logic [DW-1:0]    ret_pc,
  input  logic [FW-1:0]    alu_flags_in,
  input  logic             alu_flags_ie,
  output logic [FW-1:0]    alu_flags
);

  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               boot_buf_q, boot_buf_d;
  logic               boot_mode_q, boot_mode_d;
  logic [FW-1:0]      flags_q, flags_d;
  logic [IRQ_N-1:0]   irq_q, irq_prev_q;
  logic [IRQ_N-1:0]   imask_q, imask_d;
  logic [IRQ_N-1:0]   ipend_q, ipend_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               err_q, err_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  sr_stack_t          stack_q [NEST_DEPTH];
  sr_stack_t          stack_d [NEST_DEPTH];
  logic               irq_take_q, irq_take_d;
  logic [DW-1:0]      irq_vec_q, irq_vec_d;
  logic               ret_valid_q, ret_valid_d;
  logic [DW-1:0]      ret_pc_q, ret_pc_d;
`ifdef SREGS_IRQ_PRIO_EN
  logic [IRQ_N-1:0]   iprio_q, iprio_d;
  logic               wr_iprio;
`endif

  logic               wr_mode, wr_boot, wr_epc, wr_flags;
  logic               wr_imask, wr_ipend, wr_icause;
  logic [IRQ_N-1:0]   rise, eligible, enc_req;
  logic               has_entry, has_room;
  logic               win_valid, take, pop;
  logic [CAUSE_W-1:0] win_idx;
  sr_stack_t          top_entry;

  assign wr_mode   = sr_we && (sr_sel == DW'(SR_MODE));
  assign wr_boot   = sr_we && (sr_sel == DW'(SR_BOOT));
  assign wr_epc    = sr_we && (sr_sel == DW'(SR_EPC));
  assign wr_flags  = sr_we && (sr_sel == DW'(SR_FLAGS));
  assign wr_imask  = sr_we && (sr_sel == DW'(SR_IMASK));
  assign wr_ipend  = sr_we && (sr_sel == DW'(SR_IPEND));
  assign wr_icause = sr_we && (sr_sel == DW'(SR_ICAUSE));
`ifdef SREGS_IRQ_PRIO_EN
  assign wr_iprio  = sr_we && (sr_sel == DW'(SR_IPRIO));
`endif

  // irq_q is the synchroniser stage; the edge is seen between it and irq_prev_q.
  assign rise      = irq_q & ~irq_prev_q;
  assign has_entry = (depth_q != '0);
  assign has_room  = (depth_q < DEPTH_W'(NEST_DEPTH));

  // An iret in the same cycle blocks the take; the request stays pending.
  assign eligible = ipend_q & imask_q &
                    {IRQ_N{mode_q[MODE_IE] & instr_boundary & has_room & ~iret}};

`ifdef SREGS_IRQ_PRIO_EN
  assign enc_req = (|(eligible & iprio_q)) ? (eligible & iprio_q) : eligible;
`else
  assign enc_req = eligible;
`endif

  irq_prio_enc #(.N(IRQ_N), .IW(CAUSE_W)) u_prio_enc (
    .req  (enc_req),
    .valid(win_valid),
    .idx  (win_idx)
  );

  assign take = win_valid;
  assign pop  = iret && has_entry;

  // Top-of-stack entry is at index depth-1.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) top_entry = stack_q[i];
    end
  end

  always_comb begin
    sr_out = '0;
    case (sr_sel)
      DW'(SR_MODE):   sr_out = DW'(mode_q);
      DW'(SR_BOOT):   sr_out = DW'(boot_buf_q);
      DW'(SR_EPC):    sr_out = has_entry ? DW'(top_entry.pc) : '0;
      DW'(SR_FLAGS):  sr_out = DW'(flags_q);
      DW'(SR_IMASK):  sr_out = DW'(imask_q);
      DW'(SR_IPEND):  sr_out = DW'(ipend_q);
      DW'(SR_ICAUSE): sr_out = DW'({err_q, 3'b000, depth_q, 4'b0000, cause_q});
`ifdef SREGS_IRQ_PRIO_EN
      DW'(SR_IPRIO):  sr_out = DW'(iprio_q);
`endif
      default:        sr_out = '0;
    endcase
  end

  always_comb begin
    // Mode: software write (supervisor only), then take/pop override it.
    mode_d = mode_q;
    if (wr_mode && mode_q[MODE_SUP]) mode_d = sr_in[MODE_W-1:0];
    if (take) begin
      mode_d           = mode_q;
      mode_d[MODE_SUP] = 1'b1;
      mode_d[MODE_IE]  = 1'b0;
    end else if (pop) begin
      mode_d = top_entry.mode;
    end

    // Flags: ALU beats software; take keeps the saved value, pop restores.
    flags_d = flags_q;
    if (wr_flags)     flags_d = sr_in[FW-1:0];
    if (alu_flags_ie) flags_d = alu_flags_in;
    if (take)         flags_d = flags_q;
    else if (pop)     flags_d = top_entry.flags;

    boot_buf_d  = wr_boot ? sr_in[0] : boot_buf_q;
    boot_mode_d = boot_commit ? boot_buf_q : boot_mode_q;

    imask_d = wr_imask ? sr_in[IRQ_N-1:0] : imask_q;
`ifdef SREGS_IRQ_PRIO_EN
    iprio_d = wr_iprio ? sr_in[IRQ_N-1:0] : iprio_q;
`endif

    // Pending: clears first, new edges last so a simultaneous set wins.
    ipend_d = ipend_q;
    if (wr_ipend) ipend_d = ipend_d & ~sr_in[IRQ_N-1:0];
    for (int i = 0; i < IRQ_N; i++) begin
      if (take && (win_idx == CAUSE_W'(i))) ipend_d[i] = 1'b0;
    end
    ipend_d = ipend_d | rise;

    cause_d = take ? win_idx : cause_q;

    err_d = err_q;
    if (wr_icause)            err_d = 1'b0;
    if (iret && !has_entry)   err_d = 1'b1;

    depth_d = depth_q;
    if (take)     depth_d = depth_q + 1'b1;
    else if (pop) depth_d = depth_q - 1'b1;

    // Push lands at index depth; an EPC write edits the current top only.
    for (int i = 0; i < NEST_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (take && (depth_q == DEPTH_W'(i))) begin
        stack_d[i].pc    = pc_next;
        stack_d[i].flags = flags_q;
        stack_d[i].mode  = mode_q;
      end else if (wr_epc && (depth_q == DEPTH_W'(i + 1))) begin
        stack_d[i].pc = sr_in;
      end
    end

    irq_take_d  = take;
    irq_vec_d   = take ? (VEC_BASE + DW'({win_idx, 2'b00})) : irq_vec_q;
    ret_valid_d = pop;
    ret_pc_d    = pop ? top_entry.pc : ret_pc_q;
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 3'b001;
      boot_buf_q  <= 1'b1;
      boot_mode_q <= 1'b1;
      flags_q     <= '0;
      irq_q       <= '0;
      irq_prev_q  <= '0;
      imask_q     <= '0;
      ipend_q     <= '0;
      cause_q     <= '0;
      err_q       <= 1'b0;
      depth_q     <= '0;
      // NOTE: the save stack is a handful of flops, not a RAM, so it is
      // reset with everything else and a reset mid-handler leaves no stale entries.
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
      irq_take_q  <= 1'b0;
      irq_vec_q   <= '0;
      ret_valid_q <= 1'b0;
      ret_pc_q    <= '0;
`ifdef SREGS_IRQ_PRIO_EN
      iprio_q     <= '0;
`endif
    end else begin
      mode_q      <= mode_d;
      boot_buf_q  <= boot_buf_d;
      boot_mode_q <= boot_mode_d;
      flags_q     <= flags_d;
      irq_q       <= irq_lines;
      irq_prev_q  <= irq_q;
      imask_q     <= imask_d;
      ipend_q     <= ipend_d;
      cause_q     <= cause_d;
      err_q       <= err_d;
      depth_q     <= depth_d;
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= stack_d[i];
      irq_take_q  <= irq_take_d;
      irq_vec_q   <= irq_vec_d;
      ret_valid_q <= ret_valid_d;
      ret_pc_q    <= ret_pc_d;
`ifdef SREGS_IRQ_PRIO_EN
      iprio_q     <= iprio_d;
`endif
    end
  end

  assign boot_mode      = boot_mode_q;
  assign instr_mem_over = mode_q[MODE_INA];
  assign supervisor     = mode_q[MODE_SUP];
  assign irq_en         = mode_q[MODE_IE];
  assign irq_take       = irq_take_q;
  assign irq_vec        = irq_vec_q;
  assign ret_valid      = ret_valid_q;
  assign ret_pc         = ret_pc_q;
  assign alu_flags      = flags_q;

endmodule

// File: tb/tb_sregs_irq_nest.sv
// Directed self-checking bench for sregs_irq_nest (default parameters).
// Inputs change on the falling edge; outputs are sampled in the low phase.
module tb_sregs_irq_nest;

  logic        clk = 1'b0;
  logic        rst;
  logic        sr_we;
  logic [15:0] sr_sel;
  logic [15:0] sr_in;
  logic [15:0] sr_out;
  logic        boot_commit;
  logic        boot_mode;
  logic        instr_mem_over;
  logic        supervisor;
  logic        irq_en;
  logic [3:0]  irq_lines;
  logic        instr_boundary;
  logic [15:0] pc_next;
  logic        irq_take;
  logic [15:0] irq_vec;
  logic        iret;
  logic        ret_valid;
  logic [15:0] ret_pc;
  logic [4:0]  alu_flags_in;
  logic        alu_flags_ie;
  logic [4:0]  alu_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sregs_irq_nest dut (
    .clk           (clk),
    .rst           (rst),
    .sr_we         (sr_we),
    .sr_sel        (sr_sel),
    .sr_in         (sr_in),
    .sr_out        (sr_out),
    .boot_commit   (boot_commit),
    .boot_mode     (boot_mode),
    .instr_mem_over(instr_mem_over),
    .supervisor    (supervisor),
    .irq_en        (irq_en),
    .irq_lines     (irq_lines),
    .instr_boundary(instr_boundary),
    .pc_next       (pc_next),
    .irq_take      (irq_take),
    .irq_vec       (irq_vec),
    .iret          (iret),
    .ret_valid     (ret_valid),
    .ret_pc        (ret_pc),
    .alu_flags_in  (alu_flags_in),
    .alu_flags_ie  (alu_flags_ie),
    .alu_flags     (alu_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sr_we = 1'b0; sr_sel = '0; sr_in = '0;
    boot_commit = 1'b0; irq_lines = '0; instr_boundary = 1'b1;
    pc_next = '0; iret = 1'b0; alu_flags_in = '0; alu_flags_ie = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sr_wr(input int sel, input logic [15:0] d);
    @(negedge clk);
    sr_we = 1'b1; sr_sel = 16'(sel); sr_in = d;
    @(negedge clk);
    sr_we = 1'b0; sr_sel = '0; sr_in = '0;
  endtask

  task automatic sr_chk(input string tag, input int sel, input logic [15:0] exp);
    sr_sel = 16'(sel);
    #1;
    check(tag, 32'(sr_out), 32'(exp));
  endtask

  task automatic pulse_lines(input logic [3:0] m);
    @(negedge clk); irq_lines = m;
    @(negedge clk); irq_lines = '0;
  endtask

  task automatic wait_take(input int max_cycles, output bit seen, output logic [15:0] vec);
    seen = 1'b0;
    vec  = '0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (irq_take) begin
        seen = 1'b1;
        vec  = irq_vec;
        return;
      end
    end
  endtask

  task automatic iret_pulse();
    @(negedge clk); iret = 1'b1;
    @(negedge clk); iret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [15:0] vec;

    // Reset state and supervisor-gated MODE writes.
    do_reset();
    @(negedge clk);
    sr_chk("rst_mode", 1, 16'h0001);
    sr_chk("rst_flags", 4, 16'h0000);
    sr_chk("rst_icause", 7, 16'h0000);
    check("rst_boot_mode", 32'(boot_mode), 32'd1);
    check("rst_irq_take", 32'(irq_take), 32'd0);
    sr_wr(1, 16'h0000);
    sr_chk("mode_wr0", 1, 16'h0000);
    sr_wr(1, 16'h0007);
    sr_chk("mode_blocked", 1, 16'h0000);
    sr_wr(2, 16'h0000);
    @(negedge clk); boot_commit = 1'b1;
    @(negedge clk); boot_commit = 1'b0;
    check("boot_commit", 32'(boot_mode), 32'd0);

    // First take: lines 1 and 2 together, line 1 wins.
    do_reset();
    sr_wr(5, 16'h0006);
    sr_wr(4, 16'h000A);
    sr_wr(1, 16'h0005);
    pc_next = 16'h0123;
    pulse_lines(4'b0110);
    wait_take(10, seen, vec);
    check("take1_seen", 32'(seen), 32'd1);
    check("take1_vec", 32'(vec), 32'h0014);
    sr_chk("take1_icause", 7, 16'h0101);
    sr_chk("take1_epc", 3, 16'h0123);
    sr_chk("take1_ipend", 6, 16'h0004);
    sr_chk("take1_mode", 1, 16'h0001);

    // Nested take of line 2 from inside the handler.
    pc_next = 16'h0456;
    sr_wr(4, 16'h0015);
    sr_wr(1, 16'h0005);
    wait_take(10, seen, vec);
    check("take2_seen", 32'(seen), 32'd1);
    check("take2_vec", 32'(vec), 32'h0018);
    sr_chk("take2_icause", 7, 16'h0202);
    sr_chk("take2_epc", 3, 16'h0456);

    // Stack full: a new line-3 edge stays pending.
    sr_wr(5, 16'h000E);
    sr_wr(1, 16'h0005);
    pulse_lines(4'b1000);
    wait_take(8, seen, vec);
    check("full_no_take", 32'(seen), 32'd0);
    sr_chk("full_ipend", 6, 16'h0008);
    sr_wr(6, 16'h0008);
    sr_chk("w1c_ipend", 6, 16'h0000);

    // Unwind both levels.
    iret_pulse();
    check("iret1_valid", 32'(ret_valid), 32'd1);
    check("iret1_pc", 32'(ret_pc), 32'h0456);
    sr_chk("iret1_mode", 1, 16'h0005);
    sr_chk("iret1_flags", 4, 16'h0015);
    sr_chk("iret1_icause", 7, 16'h0102);
    @(negedge clk);
    check("iret1_pulse_end", 32'(ret_valid), 32'd0);
    iret_pulse();
    check("iret2_valid", 32'(ret_valid), 32'd1);
    check("iret2_pc", 32'(ret_pc), 32'h0123);
    sr_chk("iret2_mode", 1, 16'h0005);
    sr_chk("iret2_flags", 4, 16'h000A);
    sr_chk("iret2_epc_empty", 3, 16'h0000);

    // iret on an empty stack raises ERR; any ICAUSE write clears it.
    iret_pulse();
    check("err_no_ret", 32'(ret_valid), 32'd0);
    sr_chk("err_set", 7, 16'h8002);
    sr_wr(7, 16'h1234);
    sr_chk("err_clr", 7, 16'h0002);

    // iret and an eligible request in the same cycle: pop first, take next.
    pc_next = 16'h0200;
    pulse_lines(4'b0010);
    wait_take(10, seen, vec);
    check("take3_vec", 32'(vec), 32'h0014);
    instr_boundary = 1'b0;
    pulse_lines(4'b0100);
    repeat (3) @(negedge clk);
    sr_wr(1, 16'h0005);
    sr_chk("hold_ipend", 6, 16'h0004);
    @(negedge clk); instr_boundary = 1'b1; iret = 1'b1;
    @(negedge clk); iret = 1'b0;
    check("race_ret_valid", 32'(ret_valid), 32'd1);
    check("race_ret_pc", 32'(ret_pc), 32'h0200);
    check("race_no_take", 32'(irq_take), 32'd0);
    @(negedge clk);
    check("race_take", 32'(irq_take), 32'd1);
    check("race_vec", 32'(irq_vec), 32'h0018);
    check("race_ret_end", 32'(ret_valid), 32'd0);

    // Asynchronous reset while a handler is active.
    #2 rst = 1'b1;
    #1;
    check("rst_mid_take", 32'(irq_take), 32'd0);
    sr_chk("rst_mid_icause", 7, 16'h0000);
    sr_chk("rst_mid_epc", 3, 16'h0000);
    @(negedge clk); rst = 1'b0;

    // ALU flag strobe beats a same-cycle FLAGS write.
    @(negedge clk);
    sr_we = 1'b1; sr_sel = 16'd4; sr_in = 16'h0003;
    alu_flags_in = 5'h1C; alu_flags_ie = 1'b1;
    @(negedge clk);
    sr_we = 1'b0; alu_flags_ie = 1'b0;
    check("alu_beats_wr", 32'(alu_flags), 32'h1C);
    sr_wr(4, 16'h0003);
    check("flags_wr", 32'(alu_flags), 32'h03);

    // Priority register: lines 0 and 3 pending together.
    sr_wr(5, 16'h0009);
    sr_wr(8, 16'h0008);
    sr_wr(1, 16'h0005);
    pulse_lines(4'b1001);
    wait_take(10, seen, vec);
    check("prio_seen", 32'(seen), 32'd1);
`ifdef SREGS_IRQ_PRIO_EN
    check("prio_vec", 32'(vec), 32'h001C);
    sr_chk("prio_cause", 7, 16'h0103);
    sr_chk("prio_reg", 8, 16'h0008);
    sr_chk("prio_ipend", 6, 16'h0001);
`else
    check("prio_vec", 32'(vec), 32'h0010);
    sr_chk("prio_cause", 7, 16'h0100);
    sr_chk("prio_reg", 8, 16'h0000);
    sr_chk("prio_ipend", 6, 16'h0008);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
